iomem_router: RTL and testbench
===============================

# iomem_router

Routes the picosoc `iomem` port to up to `NUM_SLAVES` peripheral slots inside one address page, replacing ad-hoc per-peripheral decode in `top`. It registers each accepted request, drives exactly one slot's request at a time, muxes that slot's read data back, and generates the single-cycle `iomem_ready`. A per-transaction watchdog answers on behalf of slots that never respond, so a hung peripheral can never stall the CPU. Unmapped slots get the same error response.

## Interface
- `NUM_SLAVES`, default 4: number of slots, 1..16.
- `PAGE`, default 8'h03: value of `iomem_addr[31:24]` that this block serves.
- `TIMEOUT`, default 255: clk25 cycles a slot may take before forced error response, ≥1.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on timeout or unmapped slot.
- `clk25  in  1`: system clock.
- `resetn  in  1`: reset, synchronous, active-low.
- `iomem_valid  in  1`: CPU request, held until ready.
- `iomem_wstrb  in  4`: byte write strobes, 0 = read.
- `iomem_addr  in  32`: byte address.
- `iomem_wdata  in  32`: write data.
- `iomem_ready  out  1`: one-cycle completion pulse.
- `iomem_rdata  out  32`: read data, valid while `iomem_ready`=1.
- `s_valid  out  NUM_SLAVES`: one-hot slot request.
- `s_ready  in  NUM_SLAVES`: slot completion.
- `s_rdata  in  32*NUM_SLAVES`: slot read data, slot i at [32i+31:32i].
- `s_addr  out  16`: registered `iomem_addr[15:0]`.
- `s_wdata  out  32`: registered write data.
- `s_wstrb  out  4`: registered strobes.
- `err_irq  out  1`: one-cycle pulse per error response.
- `err_count  out  8`: saturating error counter.

## Operation
- Slot index is `iomem_addr[19:16]`. A request is a hit when `iomem_valid`=1, `iomem_addr[31:24]`=`PAGE`, and `iomem_ready`=0. Requests outside `PAGE` are ignored and never answered.
- FSM states and transitions:
  - IDLE: on a hit, latch the index, `s_addr`, `s_wdata` and `s_wstrb`. Go to BUSY if index < `NUM_SLAVES`, else to ERR.
  - BUSY: `s_valid[idx]`=1 and the watchdog counts.
    - If `s_ready[idx]`=1, capture `s_rdata[idx]` into `iomem_rdata`, drop `s_valid`, go to RESP.
    - Otherwise, when the count reaches `TIMEOUT`, drop `s_valid` and go to ERR.
  - ERR: set `iomem_rdata`=`ERR_DATA`, pulse `err_irq`, increment `err_count` (holds at 255), go to RESP. Writes are discarded.
  - RESP: `iomem_ready`=1 for exactly one cycle, then go to IDLE.
- `s_ready` of non-selected slots, and `s_ready` while not in BUSY, are ignored.
- In BUSY, if `s_ready` and the timeout fall on the same cycle, `s_ready` wins (normal response, no error).
- A late `s_ready` after a timeout is ignored. Slots must tolerate `s_valid` dropping without a handshake.
- `iomem_rdata` holds its last value outside RESP. It is undefined-by-contract for writes, but is still driven with the slot data.
- Reset while in any state: the FSM returns to IDLE, a pending transaction is abandoned, and no `iomem_ready` is issued.

## Timing
- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `s_valid`=0, `s_addr`=0, `s_wdata`=0, `s_wstrb`=0, `err_irq`=0, `err_count`=0, FSM=IDLE, watchdog=0.
- All outputs are registered. There are no combinational paths from `iomem_*` or `s_*` inputs to outputs.
- Slot handshake: hit at cycle 0 → `s_valid` high at cycle 1. If `s_ready` is sampled high at cycle k≥1, `iomem_ready` is high at cycle k+1. Minimum latency is 2 cycles from hit to ready.
- Watchdog: 0 in cycle 1 of BUSY, +1 per cycle. Timeout fires in the BUSY cycle where count = `TIMEOUT`, so `iomem_ready` comes `TIMEOUT`+3 cycles after the hit.
- Unmapped slot: hit at cycle 0 → ERR at 1 → `iomem_ready` at cycle 2.
- `s_addr`, `s_wdata` and `s_wstrb` are stable from the first BUSY cycle until the next hit.
- Back-to-back requests: the earliest next hit is the cycle after RESP.

## Structure
- Package `iomem_router_pkg` holds:
  - the FSM state enum (IDLE, BUSY, ERR, RESP);
  - `DEFAULT_ERR_DATA`;
  - the slot-index field positions (`SLOT_LSB`=16, `SLOT_W`=4);
  - `PAGE_MSB`/`PAGE_LSB`.
- Sub-module `iomem_watchdog` contains:
  - a clear/enable counter of width `$clog2(TIMEOUT+1)`;
  - an `expired` output.
- Everything else is one always_ff FSM plus a read-data mux.

## Test plan
- Write 0x000000A5, strobe 4'b0001, to 0x0301_0000 → `s_valid`=4'b0010 at cycle 1, `s_addr`=0, `s_wdata`=0xA5. With slot 1 ready at cycle 3, `iomem_ready` pulses at cycle 4. `err_count`=0.
- Read 0x0302_0004 with slot 2 returning 0x1234_5678 at cycle 1 → `iomem_rdata`=0x1234_5678 with `iomem_ready` at cycle 2. `s_addr`=0x0004.
- Read slot 0 that never responds, with `TIMEOUT`=8 → `s_valid[0]` drops, `err_irq` pulses, `iomem_rdata`=0xDEAD_BEEF and `iomem_ready` at cycle 11. `err_count`=1.
- Read 0x0307_0000 with `NUM_SLAVES`=4 → no `s_valid`, `iomem_ready` at cycle 2 with 0xDEAD_BEEF. Then `s_ready` coinciding with the timeout cycle on slot 3 → normal data, `err_count` unchanged.
- Assert `resetn`=0 mid-BUSY → `s_valid`=0 and no `iomem_ready`. After release, a new slot-0 read completes normally. A request at 0x0200_0000 is never acknowledged.
- Force 300 timeouts → `err_count` saturates at 255.

Source files
------------

// File: rtl/iomem_router_pkg.sv
// ============================================================================
// Module : iomem_router_pkg
// Brief  : Shared types and address-field constants for the iomem router.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iomem_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    localparam int SLOT_LSB = 16;
    localparam int SLOT_W   = 4;

    localparam int PAGE_MSB = 31;
    localparam int PAGE_LSB = 24;

endpackage

`default_nettype wire

// File: rtl/iomem_watchdog.sv
// ============================================================================
// Module : iomem_watchdog
// Brief  : Per-transaction cycle counter; expired marks the timeout cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iomem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk25,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_count;

    // Count stops at the limit so it can never wrap back into a live window.
    always_ff @(posedge clk25) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/iomem_router.sv
// ============================================================================
// Module : iomem_router
// Brief  : Routes the picosoc iomem port to one-hot peripheral slots in a page.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iomem_router
    import iomem_router_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [7:0]  PAGE       = 8'h03,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                     clk25,
    input  logic                     resetn,
    input  logic                     iomem_valid,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic                     iomem_ready,
    output logic [31:0]              iomem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic [15:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    output logic                     err_irq,
    output logic [7:0]               err_count
);

    state_t r_state;
    state_t w_state_next;

    logic [SLOT_W-1:0]     r_idx;
    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic [NUM_SLAVES-1:0] r_s_valid;
    logic [15:0]           r_s_addr;
    logic [31:0]           r_s_wdata;
    logic [3:0]            r_s_wstrb;
    logic                  r_err_irq;
    logic [7:0]            r_err_count;

    logic [SLOT_W-1:0]     w_idx;
    logic                  w_hit;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_sel_ready;
    logic [31:0]           w_sel_rdata;
    logic                  w_expired;
    logic                  w_unused_addr;

    assign w_idx    = iomem_addr[SLOT_LSB +: SLOT_W];
    assign w_hit    = iomem_valid && (iomem_addr[PAGE_MSB:PAGE_LSB] == PAGE) && !r_ready;
    assign w_mapped = ({1'b0, w_idx} < 5'(NUM_SLAVES));

    // Address bits between the slot field and the page field carry no meaning.
    assign w_unused_addr = ^iomem_addr[PAGE_LSB-1:SLOT_LSB+SLOT_W];

    always_comb begin
        w_onehot    = '0;
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_onehot[i] = (w_idx == SLOT_W'(i));
            if (r_idx == SLOT_W'(i)) begin
                w_sel_ready = s_ready[i];
                w_sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    iomem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk25   (clk25),
        .resetn  (resetn),
        .clear   (r_state != BUSY),
        .enable  (r_state == BUSY),
        .expired (w_expired)
    );

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Slot ready is checked before the watchdog so a coincident response wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_next = w_mapped ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (w_sel_ready) begin
                    w_state_next = RESP;
                end else if (w_expired) begin
                    w_state_next = ERR;
                end
            end
            ERR:     w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            r_idx       <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_s_valid   <= '0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_err_irq   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_ready   <= 1'b0;
            r_err_irq <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_idx     <= w_idx;
                        r_s_addr  <= iomem_addr[15:0];
                        r_s_wdata <= iomem_wdata;
                        r_s_wstrb <= iomem_wstrb;
                        if (w_mapped) begin
                            r_s_valid <= w_onehot;
                        end
                    end
                end
                BUSY: begin
                    if (w_sel_ready) begin
                        r_rdata   <= w_sel_rdata;
                        r_s_valid <= '0;
                        r_ready   <= 1'b1;
                    end else if (w_expired) begin
                        r_s_valid <= '0;
                    end
                end
                ERR: begin
                    r_rdata   <= ERR_DATA;
                    r_err_irq <= 1'b1;
                    r_ready   <= 1'b1;
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign s_valid     = r_s_valid;
    assign s_addr      = r_s_addr;
    assign s_wdata     = r_s_wdata;
    assign s_wstrb     = r_s_wstrb;
    assign err_irq     = r_err_irq;
    assign err_count   = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_iomem_router.sv
// ============================================================================
// Module : tb_iomem_router
// Brief  : Directed self-checking bench for iomem_router (4 slots, TIMEOUT=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iomem_router;

    logic          clk25 = 1'b0;
    logic          resetn;
    logic          iomem_valid;
    logic [3:0]    iomem_wstrb;
    logic [31:0]   iomem_addr;
    logic [31:0]   iomem_wdata;
    logic          iomem_ready;
    logic [31:0]   iomem_rdata;
    logic [3:0]    s_valid;
    logic [3:0]    s_ready;
    logic [127:0]  s_rdata;
    logic [15:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          err_irq;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    iomem_router #(
        .NUM_SLAVES (4),
        .PAGE       (8'h03),
        .TIMEOUT    (8),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk25       (clk25),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .iomem_rdata (iomem_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .err_irq     (err_irq),
        .err_count   (err_count)
    );

    always #20 clk25 = ~clk25;

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = data;
    endtask

    task automatic idle_bus();
        iomem_valid = 1'b0;
        iomem_addr  = '0;
        iomem_wstrb = '0;
        iomem_wdata = '0;
        s_ready     = '0;
    endtask

    initial begin
        bit got;
        int seen;

        resetn = 1'b0;
        idle_bus();
        s_rdata = '0;
        repeat (3) tick();

        check("rst_ready",  {31'b0, iomem_ready}, 32'h0);
        check("rst_rdata",  iomem_rdata,          32'h0);
        check("rst_svalid", {28'b0, s_valid},     32'h0);
        check("rst_saddr",  {16'b0, s_addr},      32'h0);
        check("rst_swdata", s_wdata,              32'h0);
        check("rst_swstrb", {28'b0, s_wstrb},     32'h0);
        check("rst_irq",    {31'b0, err_irq},     32'h0);
        check("rst_errcnt", {24'b0, err_count},   32'h0);

        resetn = 1'b1;
        tick();

        // Write to slot 1, slot answers at cycle 3.
        request(32'h0301_0000, 4'b0001, 32'h0000_00A5);
        tick();
        check("wr_svalid", {28'b0, s_valid}, 32'h2);
        check("wr_saddr",  {16'b0, s_addr},  32'h0);
        check("wr_swdata", s_wdata,          32'hA5);
        check("wr_swstrb", {28'b0, s_wstrb}, 32'h1);
        tick();
        tick();
        check("wr_ready_c3", {31'b0, iomem_ready}, 32'h0);
        s_ready = 4'b0010;
        tick();
        check("wr_ready_c4", {31'b0, iomem_ready}, 32'h1);
        check("wr_errcnt",   {24'b0, err_count},   32'h0);
        idle_bus();
        tick();
        check("wr_ready_c5",  {31'b0, iomem_ready}, 32'h0);
        check("wr_svalid_c5", {28'b0, s_valid},     32'h0);

        // Read slot 2, slot answers at cycle 1.
        request(32'h0302_0004, 4'b0000, 32'h0);
        tick();
        check("rd2_svalid", {28'b0, s_valid}, 32'h4);
        check("rd2_saddr",  {16'b0, s_addr},  32'h0004);
        s_ready = 4'b0100;
        s_rdata[95:64] = 32'h1234_5678;
        tick();
        check("rd2_ready", {31'b0, iomem_ready}, 32'h1);
        check("rd2_rdata", iomem_rdata,          32'h1234_5678);
        idle_bus();
        tick();
        check("rd2_ready_drop", {31'b0, iomem_ready}, 32'h0);
        check("rd2_rdata_hold", iomem_rdata,          32'h1234_5678);

        // Read slot 0 that never answers: ready at cycle TIMEOUT+3 = 11.
        request(32'h0300_0000, 4'b0000, 32'h0);
        tick();
        check("to_svalid_c1", {28'b0, s_valid}, 32'h1);
        repeat (8) tick();
        check("to_svalid_c9", {28'b0, s_valid},     32'h1);
        check("to_ready_c9",  {31'b0, iomem_ready}, 32'h0);
        tick();
        check("to_svalid_c10", {28'b0, s_valid},     32'h0);
        check("to_ready_c10",  {31'b0, iomem_ready}, 32'h0);
        tick();
        check("to_ready_c11", {31'b0, iomem_ready}, 32'h1);
        check("to_irq_c11",   {31'b0, err_irq},     32'h1);
        check("to_rdata",     iomem_rdata,          32'hDEAD_BEEF);
        check("to_errcnt",    {24'b0, err_count},   32'h1);
        idle_bus();
        tick();
        check("to_irq_c12", {31'b0, err_irq}, 32'h0);

        // Unmapped slot 7: error response at cycle 2.
        request(32'h0307_0000, 4'b0000, 32'h0);
        tick();
        check("um_svalid", {28'b0, s_valid},     32'h0);
        check("um_ready1", {31'b0, iomem_ready}, 32'h0);
        tick();
        check("um_ready2", {31'b0, iomem_ready}, 32'h1);
        check("um_rdata",  iomem_rdata,          32'hDEAD_BEEF);
        check("um_errcnt", {24'b0, err_count},   32'h2);
        idle_bus();
        tick();

        // Slot 3 answers exactly on the timeout cycle; stray slot 0 ready earlier.
        request(32'h0303_0000, 4'b0000, 32'h0);
        s_rdata[127:96] = 32'hCAFE_F00D;
        s_rdata[31:0]   = 32'h1111_1111;
        tick();
        check("race_svalid", {28'b0, s_valid}, 32'h8);
        repeat (4) tick();
        s_ready = 4'b0001;
        tick();
        check("race_stray_ignored", {31'b0, iomem_ready}, 32'h0);
        s_ready = 4'b0000;
        repeat (3) tick();
        s_ready = 4'b1000;
        tick();
        check("race_ready",  {31'b0, iomem_ready}, 32'h1);
        check("race_rdata",  iomem_rdata,          32'hCAFE_F00D);
        check("race_irq",    {31'b0, err_irq},     32'h0);
        check("race_errcnt", {24'b0, err_count},   32'h2);
        idle_bus();
        tick();

        // Reset in the middle of a BUSY transaction.
        request(32'h0300_0000, 4'b0000, 32'h0);
        tick();
        tick();
        tick();
        resetn = 1'b0;
        idle_bus();
        tick();
        check("mr_svalid", {28'b0, s_valid},     32'h0);
        check("mr_ready",  {31'b0, iomem_ready}, 32'h0);
        check("mr_errcnt", {24'b0, err_count},   32'h0);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (iomem_ready || (s_valid != 4'b0000)) seen++;
        end
        check("mr_quiet", seen, 32'd0);

        request(32'h0300_0010, 4'b0000, 32'h0);
        s_rdata[31:0] = 32'h0BAD_F00D;
        tick();
        tick();
        s_ready = 4'b0001;
        tick();
        check("mr_new_ready", {31'b0, iomem_ready}, 32'h1);
        check("mr_new_rdata", iomem_rdata,          32'h0BAD_F00D);
        idle_bus();
        tick();

        // Other page: never acknowledged.
        request(32'h0200_0000, 4'b0000, 32'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (iomem_ready || (s_valid != 4'b0000)) seen++;
        end
        check("page_ignored", seen, 32'd0);
        idle_bus();
        tick();

        // 300 timeouts saturate the error counter.
        for (int n = 0; n < 300; n++) begin
            request(32'h0301_0000, 4'b0000, 32'h0);
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                if (iomem_ready) got = 1'b1;
            end
            if (!got) begin
                check("sat_timeout_bound", 32'd0, 32'd1);
                break;
            end
            idle_bus();
            tick();
            if (n == 253) check("sat_errcnt_254", {24'b0, err_count}, 32'd254);
        end
        check("sat_errcnt", {24'b0, err_count}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
